score_tracker: RTL and testbench

Game-side score engine that sits directly upstream of the high-score comparator. It runs the play session state machine, accumulates points from hit events with a time-windowed combo multiplier, and tracks lives. It presents the running current_score to the high-score stage and pulses game_over once the final score is stable, so the comparator can latch a new record.

---
 rtl/score_tracker.sv | 127 ++++++++++++
 tb/tb_score_tracker.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/score_tracker.sv
// score_tracker
// Score engine that runs the IDLE/PLAY/DONE play session. It adds points
// for hit events using a combo multiplier that stays elevated within a
// window of cycles after each hit, and it counts down lives on misses.
//
// Ports:
//   clk           system clock, all state on rising edge
//   rst_n         asynchronous active-low reset
//   start         one-cycle pulse, begins a new game from IDLE or DONE
//   hit           one-cycle pulse, point-scoring event
//   miss          one-cycle pulse, lose one life
//   current_score registered running score (saturating)
//   combo         current multiplier, 1..COMBO_MAX
//   lives_left    remaining lives
//   playing       high while in PLAY
//   game_over     one-cycle pulse on entry to DONE
module score_tracker #(
    parameter int SCORE_W      = 8,
    parameter int LIVES        = 3,
    parameter int COMBO_MAX    = 4,
    parameter int COMBO_WINDOW = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               hit,
    input  logic               miss,
    output logic [SCORE_W-1:0] current_score,
    output logic [2:0]         combo,
    output logic [1:0]         lives_left,
    output logic               playing,
    output logic               game_over
);

    localparam int TW = $clog2(COMBO_WINDOW + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state, state_n;
    logic [SCORE_W-1:0] score_n;
    logic [2:0]         combo_n;
    logic [1:0]         lives_n;
    logic [TW-1:0]      timer, timer_n;
    logic               playing_n;
    logic               game_over_n;
    logic [SCORE_W:0]   sum;

    // One extra bit catches overflow so the score clamps instead of wrapping.
    assign sum = {1'b0, current_score} + (SCORE_W + 1)'(combo);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            current_score <= '0;
            combo         <= 3'd1;
            lives_left    <= 2'(LIVES);
            timer         <= '0;
            playing       <= 1'b0;
            game_over     <= 1'b0;
        end else begin
            state         <= state_n;
            current_score <= score_n;
            combo         <= combo_n;
            lives_left    <= lives_n;
            timer         <= timer_n;
            playing       <= playing_n;
            game_over     <= game_over_n;
        end
    end

    always_comb begin
        state_n     = state;
        score_n     = current_score;
        combo_n     = combo;
        lives_n     = lives_left;
        timer_n     = timer;
        playing_n   = playing;
        game_over_n = 1'b0;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_n   = PLAY;
                    score_n   = '0;
                    combo_n   = 3'd1;
                    lives_n   = 2'(LIVES);
                    timer_n   = '0;
                    playing_n = 1'b1;
                end
            end
            PLAY: begin
                if (miss) begin
                    // A miss discards any simultaneous hit.
                    combo_n = 3'd1;
                    timer_n = '0;
                    if (lives_left <= 2'd1) begin
                        lives_n     = 2'd0;
                        state_n     = DONE;
                        playing_n   = 1'b0;
                        game_over_n = 1'b1;
                    end else begin
                        lives_n = lives_left - 2'd1;
                    end
                end else if (hit) begin
                    // A hit on the expiry edge wins: it reloads the window
                    // and scores with the still-elevated combo.
                    score_n = sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
                    combo_n = (combo >= 3'(COMBO_MAX)) ? 3'(COMBO_MAX) : combo + 3'd1;
                    timer_n = TW'(COMBO_WINDOW);
                end else if (timer != '0) begin
                    timer_n = timer - 1'b1;
                    if (timer == TW'(1)) begin
                        combo_n = 3'd1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_score_tracker.sv
// Testbench for score_tracker: directed scenarios with fixed expected values,
// then randomized play checked against a behavioural model that reasons in
// terms of hit runs and edge distances rather than a timer.
module tb_score_tracker;

    localparam int SW   = 8;
    localparam int NL   = 3;
    localparam int CMAX = 4;
    localparam int WIN  = 16;
    localparam int SMAX = (1 << SW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          hit = 1'b0;
    logic          miss = 1'b0;
    logic [SW-1:0] current_score;
    logic [2:0]    combo;
    logic [1:0]    lives_left;
    logic          playing;
    logic          game_over;

    int total = 0;
    int bad = 0;

    score_tracker #(
        .SCORE_W(SW),
        .LIVES(NL),
        .COMBO_MAX(CMAX),
        .COMBO_WINDOW(WIN)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .hit(hit),
        .miss(miss),
        .current_score(current_score),
        .combo(combo),
        .lives_left(lives_left),
        .playing(playing),
        .game_over(game_over)
    );

    always #5 clk = ~clk;

    // Reference model: game phase 0=idle 1=play 2=done, run = hits in the
    // current combo run, last = edge index of the latest scoring hit.
    int m_phase, m_score, m_run, m_last, m_lives, m_edge;
    bit m_go;

    task automatic model_reset();
        m_phase = 0; m_score = 0; m_run = 0; m_lives = NL; m_go = 0;
    endtask

    task automatic model_edge(input bit s, input bit h, input bit m);
        int pts;
        m_edge++;
        m_go = 0;
        if (m_phase == 1) begin
            if (m) begin
                m_run = 0;
                m_lives--;
                if (m_lives == 0) begin
                    m_phase = 2;
                    m_go = 1;
                end
            end else if (h) begin
                if (m_run > 0 && (m_edge - m_last) <= WIN) m_run++;
                else m_run = 1;
                pts = (m_run < CMAX) ? m_run : CMAX;
                m_score = (m_score + pts > SMAX) ? SMAX : m_score + pts;
                m_last = m_edge;
            end
        end else if (s) begin
            m_phase = 1; m_score = 0; m_run = 0; m_lives = NL;
        end
    endtask

    function automatic int model_combo();
        if (m_phase != 0 && m_run > 0 && (m_edge - m_last) < WIN)
            return (m_run + 1 < CMAX) ? m_run + 1 : CMAX;
        return 1;
    endfunction

    task automatic step(input bit s, input bit h, input bit m);
        start = s; hit = h; miss = m;
        @(posedge clk);
        model_edge(s, h, m);
        #1;
        start = 0; hit = 0; miss = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0);
    endtask

    // Finish any running game and begin a fresh one (bounded).
    task automatic new_game();
        for (int i = 0; i < NL + 1 && playing; i++) step(0, 0, 1);
        total++;
        if (playing !== 1'b0) begin
            bad++; $display("FAIL new_game_end got playing=%0b want 0", playing);
        end
        step(1, 0, 0);
    endtask

    task automatic test_reset();
        rst_n = 0; model_reset();
        #12;
        rst_n = 1;
        @(negedge clk);
        total++;
        if ({current_score, combo, lives_left, playing, game_over} !== {8'd0, 3'd1, 2'd3, 1'b0, 1'b0}) begin
            bad++; $display("FAIL reset_state got score=%0d combo=%0d lives=%0d playing=%0b go=%0b", current_score, combo, lives_left, playing, game_over);
        end
        // Drive to 37 then abort with reset.
        step(1, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 1, 0);
        idle(WIN + 1);
        step(0, 1, 0); step(0, 1, 0);
        total++;
        if (current_score !== 8'd37) begin
            bad++; $display("FAIL reset_prescore got=%0d want=37", current_score);
        end
        rst_n = 0; model_reset();
        #2;
        total++;
        if ({current_score, combo, lives_left, playing, game_over} !== {8'd0, 3'd1, 2'd3, 1'b0, 1'b0}) begin
            bad++; $display("FAIL reset_midgame got score=%0d combo=%0d lives=%0d playing=%0b go=%0b", current_score, combo, lives_left, playing, game_over);
        end
        @(negedge clk);
        rst_n = 1;
        @(posedge clk); #1;
        m_edge++;
        total++;
        if (game_over !== 1'b0 || playing !== 1'b0) begin
            bad++; $display("FAIL reset_no_go got go=%0b playing=%0b want 0 0", game_over, playing);
        end
    endtask

    task automatic test_combo_build();
        int exp_s[5] = '{1, 3, 6, 10, 14};
        int exp_c[5] = '{2, 3, 4, 4, 4};
        step(1, 0, 0);
        total++;
        if ({current_score, combo, lives_left, playing} !== {8'd0, 3'd1, 2'd3, 1'b1}) begin
            bad++; $display("FAIL start_entry got score=%0d combo=%0d lives=%0d playing=%0b", current_score, combo, lives_left, playing);
        end
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 0);
            total++;
            if (current_score !== SW'(exp_s[i]) || combo !== 3'(exp_c[i])) begin
                bad++; $display("FAIL combo_build[%0d] got score=%0d combo=%0d want %0d %0d", i, current_score, combo, exp_s[i], exp_c[i]);
            end
            idle(1);
        end
    endtask

    task automatic test_window();
        new_game();
        step(0, 1, 0);
        idle(WIN - 1);
        total++;
        if (combo !== 3'd2) begin
            bad++; $display("FAIL window_hold got combo=%0d want 2", combo);
        end
        step(0, 1, 0);
        total++;
        if (current_score !== 8'd3) begin
            bad++; $display("FAIL window_edge got=%0d want=3", current_score);
        end
        new_game();
        step(0, 1, 0);
        idle(WIN);
        total++;
        if (combo !== 3'd1 || current_score !== 8'd1) begin
            bad++; $display("FAIL window_expire got combo=%0d score=%0d want 1 1", combo, current_score);
        end
        step(0, 1, 0);
        total++;
        if (current_score !== 8'd2) begin
            bad++; $display("FAIL window_late got=%0d want=2", current_score);
        end
    endtask

    task automatic test_saturation();
        new_game();
        step(0, 1, 0); step(0, 1, 0);
        idle(WIN + 1);
        for (int i = 0; i < 3 + 61; i++) step(0, 1, 0);
        total++;
        if (current_score !== 8'd253 || combo !== 3'd4) begin
            bad++; $display("FAIL sat_pre got score=%0d combo=%0d want 253 4", current_score, combo);
        end
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0);
            total++;
            if (current_score !== 8'd255) begin
                bad++; $display("FAIL sat_hit[%0d] got=%0d want=255", i, current_score);
            end
        end
    endtask

    task automatic test_lives();
        int exp_l[3] = '{2, 1, 0};
        new_game();
        step(0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1);
            total++;
            if (lives_left !== 2'(exp_l[i]) || combo !== 3'd1 || game_over !== (i == 2) || current_score !== 8'd1) begin
                bad++; $display("FAIL miss[%0d] got lives=%0d combo=%0d go=%0b score=%0d", i, lives_left, combo, game_over, current_score);
            end
        end
        total++;
        if (playing !== 1'b0) begin
            bad++; $display("FAIL done_playing got=%0b want=0", playing);
        end
        step(0, 1, 0);
        total++;
        if (game_over !== 1'b0 || current_score !== 8'd1 || lives_left !== 2'd0) begin
            bad++; $display("FAIL done_hold got go=%0b score=%0d lives=%0d want 0 1 0", game_over, current_score, lives_left);
        end
        step(1, 0, 0);
        total++;
        if ({current_score, lives_left, playing, game_over} !== {8'd0, 2'd3, 1'b1, 1'b0}) begin
            bad++; $display("FAIL restart got score=%0d lives=%0d playing=%0b go=%0b", current_score, lives_left, playing, game_over);
        end
    endtask

    task automatic test_hit_miss();
        new_game();
        step(0, 1, 0); step(0, 1, 0); step(0, 1, 0);
        step(0, 1, 1);
        total++;
        if (current_score !== 8'd6 || combo !== 3'd1 || lives_left !== 2'd2) begin
            bad++; $display("FAIL hit_miss got score=%0d combo=%0d lives=%0d want 6 1 2", current_score, combo, lives_left);
        end
    endtask

    task automatic test_random();
        int hp;
        int ec;
        for (int blk = 0; blk < 20; blk++) begin
            hp = $urandom_range(5, 60);
            for (int i = 0; i < 100; i++) begin
                step($urandom_range(0, 99) < 4, $urandom_range(0, 99) < hp, $urandom_range(0, 99) < 3);
                ec = model_combo();
                total++;
                if (current_score !== SW'(m_score) || combo !== 3'(ec) || lives_left !== 2'(m_lives) ||
                    playing !== (m_phase == 1) || game_over !== m_go) begin
                    bad++;
                    $display("FAIL random[%0d] got s=%0d c=%0d l=%0d p=%0b g=%0b want s=%0d c=%0d l=%0d p=%0b g=%0b",
                             blk * 100 + i, current_score, combo, lives_left, playing, game_over,
                             m_score, ec, m_lives, m_phase == 1, m_go);
                end
            end
        end
    endtask

    initial begin
        m_edge = 0; m_last = 0;
        model_reset();
        test_reset();
        test_combo_build();
        test_window();
        test_saturation();
        test_lives();
        test_hit_miss();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

endmodule
